// File: rtl/seg7_pkg.sv
// Shared segment constants for the 7-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}, so segment a is bit 0.
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Hex glyphs 0..F
    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side bundle of the scan driver: data and control in, pin drive out.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);

    logic                    en;
    logic [4*NUM_DIGITS-1:0] data;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   dig;
    logic                    frame;

    modport master (output en, data, load, blank, input seg, dig, frame);
    modport slave  (input en, data, load, blank, output seg, dig, frame);

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] code;

    assign code = SEG_CODE[nibble];

    // Explicit mapping from glyph bits to segment pin positions
    assign seg[SEG_A] = code[SEG_A];
    assign seg[SEG_B] = code[SEG_B];
    assign seg[SEG_C] = code[SEG_C];
    assign seg[SEG_D] = code[SEG_D];
    assign seg[SEG_E] = code[SEG_E];
    assign seg[SEG_F] = code[SEG_F];
    assign seg[SEG_G] = code[SEG_G];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with double-buffered data and per-digit blanking.
// Define SEG7_LZ_SUPPRESS_EN to enable leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_MASK = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_MASK = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DW-1:0]         active;
    logic [DW-1:0]         pending;
    logic                  pend;
    logic [3:0]            nibble;
    logic [6:0]            seg_code;
    logic [NUM_DIGITS-1:0] hidden;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  boundary;
    logic                  lit;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;
    logic                  frame_q;

    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) nibble = active[4*k +: 4];
        end
    end

    seg7_hex_decode u_decode (
        .nibble (nibble),
        .seg    (seg_code)
    );

`ifdef SEG7_LZ_SUPPRESS_EN
    // A digit is suppressed while it and everything above it read zero; digit 0 never is
    always_comb begin
        logic run;
        run    = 1'b1;
        hidden = bus.blank;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run       = run & (active[4*k +: 4] == 4'h0);
            hidden[k] = hidden[k] | run;
        end
    end
`else
    assign hidden = bus.blank;
`endif

    assign onehot   = NUM_DIGITS'(1) << idx;
    assign boundary = bus.en && (cnt == '0) && (idx == '0);
    assign lit      = bus.en && (cnt != '0) && !hidden[idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            active  <= '0;
            pending <= '0;
            pend    <= 1'b0;
            seg_q   <= SEG_OFF ^ SEG_MASK;
            dig_q   <= DIG_MASK;
            frame_q <= 1'b0;
        end else begin
            if (bus.en) begin
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            // The boundary takes the pre-LOAD pending value; a same-cycle LOAD re-arms pend
            if (boundary && pend) begin
                active <= pending;
                pend   <= 1'b0;
            end
            if (bus.load) begin
                pending <= bus.data;
                pend    <= 1'b1;
            end
            seg_q   <= (lit ? seg_code : SEG_OFF) ^ SEG_MASK;
            dig_q   <= (lit ? onehot : '0) ^ DIG_MASK;
            frame_q <= boundary;
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig   = dig_q;
    assign bus.frame = frame_q;

endmodule
